// File: rtl/seq_mul_ctrl_pkg.sv
// rtl/seq_mul_ctrl_pkg.sv - shared multiplier definitions: operand width and iteration count
package seq_mul_ctrl_pkg;

  // Operand width of the datapath; the adder is a fixed 32-bit CLA
  localparam int MUL_WIDTH = 32;

  // One shift-add iteration per multiplier bit
  localparam int MUL_ITERS = 32;

  // Iteration counter width and the index of the final iteration
  localparam int                    MUL_CNT_W     = $clog2(MUL_ITERS);
  localparam logic [MUL_CNT_W-1:0]  MUL_LAST_ITER = MUL_CNT_W'(MUL_ITERS - 1);

endpackage

// File: rtl/cla_32_bit.sv
// rtl/cla_32_bit.sv - 32-bit carry-lookahead adder built from 4-bit lookahead groups
module cla_32_bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_c;
  logic        w_cout;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Full lookahead inside each 4-bit group; group carries chain through group generate/propagate
  always_comb begin
    logic c_grp;
    logic grp_g;
    logic grp_p;
    w_c    = '0;
    c_grp  = i_cin;
    grp_g  = 1'b0;
    grp_p  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w_c[4*k]   = c_grp;
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & c_grp);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & c_grp);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & c_grp);
      grp_g = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
            | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
            | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      grp_p = w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_p[4*k];
      c_grp = grp_g | (grp_p & c_grp);
    end
    w_cout = c_grp;
  end

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_cout;

endmodule

// File: rtl/seq_mul_ctrl.sv
// rtl/seq_mul_ctrl.sv - unsigned 32x32->64 shift-add multiplier, one iteration per clock
module seq_mul_ctrl
  import seq_mul_ctrl_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_load;
  logic                 w_busy;
  logic                 w_done;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic [MUL_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;

  // Add the multiplicand only when the current multiplier bit is set
  assign w_addend = r_acc_lo[0] ? r_mcand : '0;

  cla_32_bit u_cla (
    .i_a    (r_acc_hi),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // State register; reset overrides any pending start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and status decode; start is only honoured in IDLE and DONE
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_RUN;
          w_load = 1'b1;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (r_count == MUL_LAST_ITER) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_next = ST_RUN;
          w_load = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Operand capture and shift-add datapath; the adder carry-out becomes the new MSB of acc_hi
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_count  <= '0;
    end else if (w_load) begin
      r_mcand  <= a;
      r_acc_hi <= '0;
      r_acc_lo <= b;
      r_count  <= '0;
    end else if (r_state == ST_RUN) begin
      {r_acc_hi, r_acc_lo} <= {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};
      r_count              <= r_count + 1'b1;
    end
  end

  assign busy    = w_busy;
  assign done    = w_done;
  assign product = {r_acc_hi, r_acc_lo};

endmodule
